// File: rtl/bht_gshare.sv
// Branch history table of saturating counters, bimodal (GHR_W=0) or gshare indexed.
// A hardware sweep loads INIT_CTR into every entry after reset before predictions start.
module bht_gshare #(
  parameter  int unsigned ENTRIES  = 32,
  parameter  int unsigned CTR_W    = 2,
  parameter  int unsigned GHR_W    = 0,
  parameter  int unsigned INIT_CTR = 1,
  parameter  int unsigned PC_W     = 32,
  localparam int unsigned IDX_W    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             rd_en,
  input  logic [PC_W-1:0]  rd_pc,
  output logic             rd_valid,
  output logic             rd_taken,
  output logic [CTR_W-1:0] rd_ctr,
  output logic [IDX_W-1:0] rd_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic [15:0]      mispredict_cnt
);

  if (ENTRIES < 4 || ENTRIES > 1024 || (1 << IDX_W) != ENTRIES || CTR_W < 2 || CTR_W > 4 ||
      GHR_W > IDX_W || INIT_CTR >= (1 << CTR_W) || PC_W < IDX_W + 2) begin : g_bad_param
    $error("bht_gshare: parameter out of range");
  end

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  typedef enum logic {StInit, StRun} state_e;

  state_e           r_state, w_state_next;
  logic [IDX_W-1:0] r_ptr;
  logic [CTR_W-1:0] r_table [ENTRIES];
  logic [15:0]      r_mis_cnt;
  logic             r_rd_valid, r_rd_taken;
  logic [CTR_W-1:0] r_rd_ctr;
  logic [IDX_W-1:0] r_rd_idx;

  logic             w_run, w_upd_act, w_rd_act;
  logic [IDX_W-1:0] w_ghr_idx, w_rd_idx;
  logic [CTR_W-1:0] w_upd_old, w_upd_new, w_rd_val;
  logic             w_unused_pc;

  assign w_run       = (r_state == StRun);
  assign w_upd_act   = w_run & upd_en;
  assign w_rd_act    = w_run & rd_en;
  assign w_unused_pc = ^rd_pc;

  // History is shifted only by resolved branches, so it never needs repair.
  if (GHR_W > 0) begin : g_ghr
    logic [GHR_W-1:0] r_ghr;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_ghr <= '0;
      end else if (w_upd_act) begin
        r_ghr <= (r_ghr << 1) | GHR_W'(upd_taken);
      end
    end
    assign w_ghr_idx = IDX_W'(r_ghr);
  end else begin : g_no_ghr
    assign w_ghr_idx = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StInit;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StInit) r_ptr <= r_ptr + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == StInit && r_ptr == IDX_W'(ENTRIES - 1)) w_state_next = StRun;
  end

  always_comb begin
    w_upd_old = r_table[upd_idx];
    w_upd_new = w_upd_old;
    if (upd_taken && w_upd_old != CTR_MAX) begin
      w_upd_new = w_upd_old + CTR_W'(1);
    end else if (!upd_taken && w_upd_old != '0) begin
      w_upd_new = w_upd_old - CTR_W'(1);
    end
  end

  // Table storage is not reset; the init sweep rewrites every entry instead.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_table[r_ptr] <= CTR_INIT;
    end else if (upd_en) begin
      r_table[upd_idx] <= w_upd_new;
    end
  end

  assign w_rd_idx = rd_pc[IDX_W+1:2] ^ w_ghr_idx;
  assign w_rd_val = (w_upd_act && upd_idx == w_rd_idx) ? w_upd_new : r_table[w_rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_taken <= 1'b0;
      r_rd_ctr   <= '0;
      r_rd_idx   <= '0;
    end else begin
      r_rd_valid <= w_rd_act;
      if (w_rd_act) begin
        r_rd_idx   <= w_rd_idx;
        r_rd_ctr   <= w_rd_val;
        r_rd_taken <= w_rd_val[CTR_W-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mis_cnt <= '0;
    end else if (w_upd_act && upd_mispredict && r_mis_cnt != 16'hFFFF) begin
      r_mis_cnt <= r_mis_cnt + 16'd1;
    end
  end

  assign ready          = w_run;
  assign rd_valid       = r_rd_valid;
  assign rd_taken       = r_rd_taken;
  assign rd_ctr         = r_rd_ctr;
  assign rd_idx         = r_rd_idx;
  assign mispredict_cnt = r_mis_cnt;

endmodule

// File: tb/tb_bht_gshare.sv
// Drives a bimodal and a GHR_W=4 gshare table with identical stimulus and checks both
// against a table-of-integers model.
module tb_bht_gshare;

  localparam int ENT = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_en = 1'b0;
  logic [31:0] rd_pc = '0;
  logic        upd_en = 1'b0;
  logic [4:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;

  logic        b_ready, b_rv, b_rt, g_ready, g_rv, g_rt;
  logic [1:0]  b_ctr, g_ctr;
  logic [4:0]  b_idx, g_idx;
  logic [15:0] b_cnt, g_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state: counters as plain integers, history as the last four outcomes.
  int         m_sweep;
  int         mb [ENT];
  int         mg [ENT];
  logic [3:0] m_ghr;
  int         m_cnt, m_rv, m_bctr, m_bidx, m_gctr, m_gidx;

  always #5 clk = ~clk;

  bht_gshare #(.ENTRIES(ENT), .CTR_W(2), .GHR_W(0)) dut_bi (
    .clk(clk), .reset(reset), .ready(b_ready), .rd_en(rd_en), .rd_pc(rd_pc),
    .rd_valid(b_rv), .rd_taken(b_rt), .rd_ctr(b_ctr), .rd_idx(b_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .mispredict_cnt(b_cnt)
  );

  bht_gshare #(.ENTRIES(ENT), .CTR_W(2), .GHR_W(4)) dut_gs (
    .clk(clk), .reset(reset), .ready(g_ready), .rd_en(rd_en), .rd_pc(rd_pc),
    .rd_valid(g_rv), .rd_taken(g_rt), .rd_ctr(g_ctr), .rd_idx(g_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .mispredict_cnt(g_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input logic t);
    if (t && v < 3) return v + 1;
    if (!t && v > 0) return v - 1;
    return v;
  endfunction

  task automatic model_reset();
    m_sweep = 0; m_ghr = '0; m_cnt = 0; m_rv = 0;
    m_bctr = 0; m_bidx = 0; m_gctr = 0; m_gidx = 0;
  endtask

  task automatic compare_all();
    check_eq("b_ready", b_ready, (m_sweep == ENT));
    check_eq("g_ready", g_ready, (m_sweep == ENT));
    check_eq("b_valid", b_rv, m_rv);
    check_eq("g_valid", g_rv, m_rv);
    check_eq("b_ctr", b_ctr, m_bctr);
    check_eq("g_ctr", g_ctr, m_gctr);
    check_eq("b_taken", b_rt, m_bctr / 2);
    check_eq("g_taken", g_rt, m_gctr / 2);
    check_eq("b_idx", b_idx, m_bidx);
    check_eq("g_idx", g_idx, m_gidx);
    check_eq("b_miscnt", b_cnt, m_cnt);
    check_eq("g_miscnt", g_cnt, m_cnt);
  endtask

  task automatic step(input logic re, input logic [31:0] pc, input logic ue,
                      input logic [4:0] ui, input logic ut, input logic um);
    int bi, gi;
    rd_en = re; rd_pc = pc; upd_en = ue; upd_idx = ui; upd_taken = ut; upd_mispredict = um;
    @(posedge clk);
    #1;
    if (m_sweep < ENT) begin
      m_sweep++;
      if (m_sweep == ENT) begin
        for (int i = 0; i < ENT; i++) begin
          mb[i] = 1;
          mg[i] = 1;
        end
      end
      m_rv = 0;
    end else begin
      bi = int'(pc[6:2]);
      gi = bi ^ int'(m_ghr);
      // Update before read so a same-index read observes the new value.
      if (ue) begin
        mb[ui] = sat(mb[ui], ut);
        mg[ui] = sat(mg[ui], ut);
        if (um && m_cnt < 65535) m_cnt++;
        m_ghr = {m_ghr[2:0], ut};
      end
      m_rv = re;
      if (re) begin
        m_bidx = bi; m_bctr = mb[bi];
        m_gidx = gi; m_gctr = mg[gi];
      end
    end
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int          exp_up [4];
    int          exp_dn [5];
    logic [31:0] pc;
    logic [4:0]  ui;
    exp_up = '{2, 3, 3, 3};
    exp_dn = '{2, 1, 0, 0, 0};

    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Init sweep: ready only after ENT edges.
    for (int i = 0; i < ENT; i++) begin
      check_eq("ready_early", b_ready, 1'b0);
      idle();
    end
    check_eq("ready_at_end", b_ready, 1'b1);

    for (int i = 0; i < ENT; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("t1_ctr", b_ctr, 32'd1);
    end
    idle();

    // History taken, taken, not-taken, taken -> 1101.
    step(1'b0, 32'd0, 1'b1, 5'd20, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 5'd21, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 5'd22, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 5'd23, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b0, 5'd0, 1'b0, 1'b0);
    check_eq("t4_gidx", g_idx, 32'd29);
    check_eq("t4_bidx", b_idx, 32'd16);

    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'd0, 1'b1, 5'd5, 1'b1, 1'b0);
      step(1'b1, 32'h14, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("t2_up_ctr", b_ctr, exp_up[k]);
      check_eq("t2_up_taken", b_rt, exp_up[k] / 2);
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 32'd0, 1'b1, 5'd5, 1'b0, 1'b0);
      step(1'b1, 32'h14, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("t2_dn_ctr", b_ctr, exp_dn[k]);
      check_eq("t2_dn_taken", b_rt, exp_dn[k] / 2);
    end

    step(1'b1, 32'h1C, 1'b1, 5'd7, 1'b1, 1'b0);
    check_eq("t3_bypass_ctr", b_ctr, 32'd2);
    check_eq("t3_bypass_taken", b_rt, 32'd1);

    for (int n = 0; n < 1500; n++) begin
      pc = $urandom;
      ui = 5'($urandom_range(0, ENT - 1));
      if ($urandom_range(0, 1) == 1) pc[6:2] = ui;
      step(1'($urandom), pc, 1'($urandom), ui, 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-run.
    reset = 1'b1;
    #2;
    model_reset();
    check_eq("t5_ready", b_ready, 1'b0);
    check_eq("t5_valid", b_rv, 1'b0);
    check_eq("t5_miscnt", b_cnt, 32'd0);
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < ENT; i++) begin
      ui = 5'($urandom_range(0, ENT - 1));
      step(1'b1, $urandom, 1'b1, ui, 1'($urandom), 1'b1);
    end
    for (int i = 0; i < ENT; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("t5_swept_ctr", b_ctr, 32'd1);
    end

    for (int n = 0; n < 70000; n++) begin
      ui = 5'($urandom_range(0, ENT - 1));
      step(1'($urandom), $urandom, 1'b1, ui, 1'($urandom), 1'b1);
    end
    check_eq("t6_sat", b_cnt, 32'hFFFF);
    for (int n = 0; n < 5; n++) step(1'b0, 32'd0, 1'b1, 5'd3, 1'b1, 1'b1);
    check_eq("t6_hold", b_cnt, 32'hFFFF);
    check_eq("t6_hold_g", g_cnt, 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bht_gshare.md
Name: bht_gshare

Overview:
Parametrised branch history table, successor to the fixed 32-entry 2-bit predictor in the fetch/ID path. Holds ENTRIES saturating counters of CTR_W bits.
- Bimodal mode (GHR_W=0): indexed by PC bits.
- Gshare mode (GHR_W>0): indexed by PC bits XOR a global history register.
Reads are requested in IF, with the result valid in ID. Updates come from the resolving stage (MEM/WB) using the index carried down the pipeline. A hardware init sweep replaces file preload.

Parameters:
ENTRIES, 32, number of counters; power of two, 4..1024; IDX_W = clog2(ENTRIES)
CTR_W, 2, counter width, 2..4; prediction = counter MSB
GHR_W, 0, global history bits; 0 = bimodal; must be <= IDX_W
INIT_CTR, 1, value loaded into every entry during init (01 = weak not-taken for CTR_W=2)
PC_W, 32, PC width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all registers and starts init sweep
ready  out  1  high once init sweep complete
rd_en  in  1  prediction request
rd_pc  in  PC_W  PC of instruction needing prediction; index bits rd_pc[IDX_W+1:2]
rd_valid  out  1  rd_taken/rd_ctr/rd_idx valid (one cycle after accepted rd_en)
rd_taken  out  1  predicted taken
rd_ctr  out  CTR_W  raw counter value read
rd_idx  out  IDX_W  table index used; pipeline carries it to upd_idx
upd_en  in  1  branch resolved this cycle
upd_idx  in  IDX_W  index to update
upd_taken  in  1  actual outcome, 1 = taken
upd_mispredict  in  1  resolved direction differed from prediction
mispredict_cnt  out  16  saturating count of upd_en&&upd_mispredict

Behaviour:
- Reset (async assert): FSM -> INIT, init pointer = 0, ghr = 0, ready = 0, rd_valid = 0, rd_taken = 0, rd_ctr = 0, rd_idx = 0, mispredict_cnt = 0. Table contents are not reset directly; the sweep rewrites them.
- INIT state:
  - Writes INIT_CTR to entry[ptr] each cycle; ptr increments.
  - After the write to entry ENTRIES-1, goes to RUN next cycle; ready = 1 from the first RUN cycle.
  - Total: ENTRIES cycles after reset release until ready.
  - rd_en ignored (rd_valid stays 0); upd_en ignored (no table, ghr or counter change).
- RUN state: read and update ports are independent; both can act in the same cycle.
- Read index: idx = rd_pc[IDX_W+1:2] XOR {zeros, ghr}. For GHR_W=0, idx = PC bits.
- Read latency is 1 cycle. At the edge where rd_en=1:
  - rd_valid <= 1, rd_idx <= idx, rd_ctr <= entry[idx], rd_taken <= entry[idx][CTR_W-1].
  - If rd_en=0, rd_valid <= 0 and the other read outputs hold their value.
- Update (upd_en=1):
  - If upd_taken and entry < 2^CTR_W-1, entry+1.
  - If !upd_taken and entry > 0, entry-1.
  - Otherwise unchanged (saturate at both ends, no wrap).
- Read/update collision: rd_en and upd_en in the same cycle with idx == upd_idx returns the post-update value (write-first bypass).
- GHR (GHR_W>0) updates non-speculatively: ghr <= {ghr[GHR_W-2:0], upd_taken} on each upd_en. The read index in the same cycle uses the pre-shift ghr.
- mispredict_cnt increments on upd_en && upd_mispredict and holds at 16'hFFFF.
- Reset asserted mid-RUN or mid-INIT: immediate async clear as above, then the sweep restarts at entry 0.
- No X on outputs after reset; out-of-range parameters are an elaboration error via a generate-time check.

Test Plan:
1. ENTRIES=32, CTR_W=2: release reset; ready rises exactly 32 cycles later. Reads of PC 0x00..0x7C all give rd_ctr=01, rd_taken=0, rd_valid one cycle after rd_en.
2. Saturation: 4 updates taken on idx 5 -> rd_ctr=11 (01->10->11->11). Then 5 not-taken -> 00 with no wrap. rd_taken follows the MSB at each step.
3. Bypass: upd_en idx 7 taken (ctr 01) and rd_en at PC 0x1C in the same cycle -> next cycle rd_ctr=10, rd_taken=1.
4. Gshare with GHR_W=4: updates taken, taken, not-taken, taken give ghr=1101. rd_pc=0x0000_0040 (PC idx 16) -> rd_idx=16^13=29.
5. Reset mid-operation: after trained entries, assert reset for 1 cycle -> ready=0, rd_valid=0, mispredict_cnt=0. After 32 cycles all entries read 01. upd_en and rd_en during the sweep cause no change.
6. Counter saturation: 70000 upd_en with upd_mispredict=1 -> mispredict_cnt=16'hFFFF and stays there.
